// File: rtl/raster_pkg.sv
// Shared types for the line rasterizer: FSM states, coordinate and error widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package raster_pkg;

   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;

   // Unsigned on-screen coordinate.
   typedef logic [9:0] coord_t;

   // Signed Bresenham working width: holds +/-1023 deltas and their sum.
   typedef logic signed [11:0] err_t;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      SETUP,
      DRAW,
      DONE
   } state_t;

endpackage

// File: rtl/line_stepper.sv
// Bresenham datapath: holds position, error and step directions for one segment.
// Latency: load/step take effect on the next clock; nxt_x/nxt_y show that value now.
// Backpressure: none; the caller decides when to load or step.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   load                 capture a new segment (x0,y0)->(x1,y1); position becomes (x0,y0)
//   step                 advance one Bresenham step (ignored while load is high)
//   x0, y0, x1, y1       segment endpoints
//   nxt_x, nxt_y         position that will be registered at the next edge
//   at_end               current registered position equals the segment end point
module line_stepper
   import raster_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       step,
   input  logic [9:0] x0,
   input  logic [9:0] y0,
   input  logic [9:0] x1,
   input  logic [9:0] y1,
   output logic [9:0] nxt_x,
   output logic [9:0] nxt_y,
   output logic       at_end
);

   err_t x_q, x_d, y_q, y_d;
   err_t xe_q, xe_d, ye_q, ye_d;
   err_t dx_q, dx_d, dy_q, dy_d;
   err_t err_q, err_d;
   logic sxn_q, sxn_d, syn_q, syn_d;

   logic signed [12:0] e2, dx_e, dy_e;
   logic               step_x, step_y;
   err_t               adx, ady;

   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      xe_d  = xe_q;
      ye_d  = ye_q;
      dx_d  = dx_q;
      dy_d  = dy_q;
      err_d = err_q;
      sxn_d = sxn_q;
      syn_d = syn_q;

      // 13-bit compare so that 2*err cannot wrap.
      e2     = {err_q, 1'b0};
      dx_e   = {dx_q[11], dx_q};
      dy_e   = {dy_q[11], dy_q};
      step_x = (e2 >= dy_e);
      step_y = (e2 <= dx_e);

      adx = (x1 >= x0) ? ({2'b00, x1} - {2'b00, x0}) : ({2'b00, x0} - {2'b00, x1});
      ady = (y1 >= y0) ? ({2'b00, y1} - {2'b00, y0}) : ({2'b00, y0} - {2'b00, y1});

      if (load) begin
         x_d   = {2'b00, x0};
         y_d   = {2'b00, y0};
         xe_d  = {2'b00, x1};
         ye_d  = {2'b00, y1};
         dx_d  = adx;
         dy_d  = -ady;
         err_d = adx - ady;
         sxn_d = (x1 < x0);
         syn_d = (y1 < y0);
      end else if (step) begin
         // Both axis updates may land in the same cycle (diagonal step).
         if (step_x) begin
            err_d = err_d + dy_q;
            x_d   = sxn_q ? (x_q - 12'sd1) : (x_q + 12'sd1);
         end
         if (step_y) begin
            err_d = err_d + dx_q;
            y_d   = syn_q ? (y_q - 12'sd1) : (y_q + 12'sd1);
         end
      end
   end

   assign nxt_x  = x_d[9:0];
   assign nxt_y  = y_d[9:0];
   assign at_end = (x_q == xe_q) && (y_q == ye_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q   <= '0;
         y_q   <= '0;
         xe_q  <= '0;
         ye_q  <= '0;
         dx_q  <= '0;
         dy_q  <= '0;
         err_q <= '0;
         sxn_q <= 1'b0;
         syn_q <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         xe_q  <= xe_d;
         ye_q  <= ye_d;
         dx_q  <= dx_d;
         dy_q  <= dy_d;
         err_q <= err_d;
         sxn_q <= sxn_d;
         syn_q <= syn_d;
      end
   end

endmodule

// File: rtl/line_rasterizer.sv
// Clears the frame buffer write side, then draws 1-bit Bresenham lines one pixel per clock.
// Latency: first pixel of a segment is registered 2 edges after the handshake; clear is H_RES*V_RES clocks.
// Backpressure: line_ready only in IDLE; outputs hold whenever no new pixel is emitted.
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   frame_clk_rising_edge   frame boundary pulse; leaves DONE and restarts the clear
//   line_valid/line_ready   segment handshake on x0,y0,x1,y1
//   frame_end               no more segments this frame (remembered if it arrives while busy)
//   DrawX, DrawY, draw_data registered pixel write (data 0 while clearing, 1 on lines)
//   frame_done              write buffer holds a complete frame
// Build option: define RASTER_CLIP_EN to suppress pixels outside H_RES x V_RES.
module line_rasterizer
   import raster_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
)(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk_rising_edge,
   input  logic       line_valid,
   output logic       line_ready,
   input  logic [9:0] x0,
   input  logic [9:0] y0,
   input  logic [9:0] x1,
   input  logic [9:0] y1,
   input  logic       frame_end,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       draw_data,
   output logic       frame_done
);

   localparam coord_t H_MAX = coord_t'(H_RES - 1);
   localparam coord_t V_MAX = coord_t'(V_RES - 1);

   state_t state_q, state_d;
   coord_t scan_x_q, scan_x_d, scan_y_q, scan_y_d;
   coord_t lx0_q, lx0_d, ly0_q, ly0_d, lx1_q, lx1_d, ly1_q, ly1_d;
   logic   pend_q, pend_d;
   coord_t draw_x_q, draw_x_d, draw_y_q, draw_y_d;
   logic   draw_data_q, draw_data_d;
   logic   frame_done_q, frame_done_d;
   logic   line_ready_q, line_ready_d;

   logic   stp_load, stp_step, stp_end;
   coord_t stp_x, stp_y;
   logic   on_screen;
   logic   end_req;

   line_stepper u_stepper (
      .clk    (Clk),
      .reset  (Reset),
      .load   (stp_load),
      .step   (stp_step),
      .x0     (lx0_q),
      .y0     (ly0_q),
      .x1     (lx1_q),
      .y1     (ly1_q),
      .nxt_x  (stp_x),
      .nxt_y  (stp_y),
      .at_end (stp_end)
   );

`ifdef RASTER_CLIP_EN
   // Off-screen pixels are stepped through but not written.
   assign on_screen = (stp_x <= H_MAX) && (stp_y <= V_MAX);
`else
   assign on_screen = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      scan_x_d     = scan_x_q;
      scan_y_d     = scan_y_q;
      lx0_d        = lx0_q;
      ly0_d        = ly0_q;
      lx1_d        = lx1_q;
      ly1_d        = ly1_q;
      pend_d       = pend_q;
      draw_x_d     = draw_x_q;
      draw_y_d     = draw_y_q;
      draw_data_d  = draw_data_q;
      stp_load     = 1'b0;
      stp_step     = 1'b0;
      end_req      = 1'b0;

      case (state_q)
         CLEAR: begin
            draw_x_d    = scan_x_q;
            draw_y_d    = scan_y_q;
            draw_data_d = 1'b0;
            if (frame_end) pend_d = 1'b1;
            if (scan_x_q == H_MAX) begin
               scan_x_d = '0;
               if (scan_y_q == V_MAX) begin
                  scan_y_d = '0;
                  state_d  = IDLE;
               end else begin
                  scan_y_d = scan_y_q + 10'd1;
               end
            end else begin
               scan_x_d = scan_x_q + 10'd1;
            end
         end

         IDLE: begin
            // A frame_end remembered from a busy period acts like one arriving now.
            end_req = frame_end | pend_q;
            if (line_valid && line_ready_q) begin
               lx0_d   = x0;
               ly0_d   = y0;
               lx1_d   = x1;
               ly1_d   = y1;
               pend_d  = end_req;
               state_d = SETUP;
            end else if (end_req) begin
               pend_d  = 1'b0;
               state_d = DONE;
            end
         end

         SETUP: begin
            // The stepper is loaded here and its start point goes straight to the outputs.
            stp_load = 1'b1;
            if (frame_end) pend_d = 1'b1;
            if (on_screen) begin
               draw_x_d    = stp_x;
               draw_y_d    = stp_y;
               draw_data_d = 1'b1;
            end
            state_d = DRAW;
         end

         DRAW: begin
            // The current point was already emitted; at the end point nothing new is written.
            if (stp_end) begin
               state_d = (pend_q || frame_end) ? DONE : IDLE;
               pend_d  = 1'b0;
            end else begin
               stp_step = 1'b1;
               if (frame_end) pend_d = 1'b1;
               if (on_screen) begin
                  draw_x_d    = stp_x;
                  draw_y_d    = stp_y;
                  draw_data_d = 1'b1;
               end
            end
         end

         DONE: begin
            if (frame_clk_rising_edge) begin
               scan_x_d = '0;
               scan_y_d = '0;
               state_d  = CLEAR;
            end
         end

         default: begin
            state_d = CLEAR;
         end
      endcase

      line_ready_d = (state_d == IDLE);
      frame_done_d = (state_d == DONE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= CLEAR;
         scan_x_q     <= '0;
         scan_y_q     <= '0;
         lx0_q        <= '0;
         ly0_q        <= '0;
         lx1_q        <= '0;
         ly1_q        <= '0;
         pend_q       <= 1'b0;
         draw_x_q     <= '0;
         draw_y_q     <= '0;
         draw_data_q  <= 1'b0;
         frame_done_q <= 1'b0;
         line_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         scan_x_q     <= scan_x_d;
         scan_y_q     <= scan_y_d;
         lx0_q        <= lx0_d;
         ly0_q        <= ly0_d;
         lx1_q        <= lx1_d;
         ly1_q        <= ly1_d;
         pend_q       <= pend_d;
         draw_x_q     <= draw_x_d;
         draw_y_q     <= draw_y_d;
         draw_data_q  <= draw_data_d;
         frame_done_q <= frame_done_d;
         line_ready_q <= line_ready_d;
      end
   end

   assign DrawX      = draw_x_q;
   assign DrawY      = draw_y_q;
   assign draw_data  = draw_data_q;
   assign frame_done = frame_done_q;
   assign line_ready = line_ready_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer on a reduced 32x16 raster.
// Expected pixels are queued when a segment is driven and popped when the outputs change to a drawn pixel.
// Timing of handshake, first pixel and return to idle is checked per segment.
`timescale 1ns/1ps
module tb_line_rasterizer;

   localparam int H  = 32;
   localparam int V  = 16;
   localparam int HV = H * V;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk_rising_edge = 1'b0;
   logic       line_valid = 1'b0;
   logic       frame_end = 1'b0;
   logic [9:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic       line_ready, draw_data, frame_done;
   logic [9:0] DrawX, DrawY;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int hs_cyc  = 0;
   int pix_cnt = 0;
   int first_cyc = -1;
   int rel = 0;
   int t = 0;

   logic [20:0] exp_q[$];
   logic [20:0] prev_pix = '0;
   logic [20:0] mon_cur;
   logic [20:0] mon_exp;

   line_rasterizer #(.H_RES(H), .V_RES(V)) dut (
      .Clk                   (Clk),
      .Reset                 (Reset),
      .frame_clk_rising_edge (frame_clk_rising_edge),
      .line_valid            (line_valid),
      .line_ready            (line_ready),
      .x0                    (x0),
      .y0                    (y0),
      .x1                    (x1),
      .y1                    (y1),
      .frame_end             (frame_end),
      .DrawX                 (DrawX),
      .DrawY                 (DrawY),
      .draw_data             (draw_data),
      .frame_done            (frame_done)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pixel monitor: a drawn pixel is any change of the outputs with draw_data high.
   always @(negedge Clk) begin
      mon_cur = {DrawX, DrawY, draw_data};
      if (!Reset && draw_data && (mon_cur != prev_pix)) begin
         if (exp_q.size() == 0) begin
            check_eq("extra_pix", mon_cur, 0);
         end else begin
            mon_exp = exp_q.pop_front();
            check_eq("pix", mon_cur, mon_exp);
         end
         if (pix_cnt == 0) first_cyc = cyc;
         pix_cnt++;
      end
      prev_pix = mon_cur;
   end

   task automatic push_pix(input int x, input int y);
      exp_q.push_back({x[9:0], y[9:0], 1'b1});
   endtask

   task automatic wait_ready(input string tag, output int at);
      int n = 0;
      while (!line_ready && n < 4 * HV) begin
         @(negedge Clk);
         n++;
      end
      check_eq({tag, "_ready_timeout"}, line_ready, 1);
      at = cyc;
   endtask

   task automatic wait_done(input string tag, output int at);
      int n = 0;
      while (!frame_done && n < 4 * HV) begin
         @(negedge Clk);
         n++;
      end
      check_eq({tag, "_done_timeout"}, frame_done, 1);
      at = cyc;
   endtask

   task automatic send_line(input int ax, input int ay, input int bx, input int by, input logic fe);
      int n = 0;
      line_valid = 1'b1;
      frame_end  = fe;
      x0 = ax[9:0]; y0 = ay[9:0]; x1 = bx[9:0]; y1 = by[9:0];
      while (!line_ready && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check_eq("handshake_timeout", line_ready, 1);
      hs_cyc    = cyc;
      pix_cnt   = 0;
      first_cyc = -1;
      @(negedge Clk);
      line_valid = 1'b0;
      frame_end  = 1'b0;
   endtask

   task automatic run_line(input string tag, input int ax, input int ay, input int bx, input int by,
                           input int k, input logic fe);
      int at;
      send_line(ax, ay, bx, by, fe);
      if (fe) wait_done(tag, at);
      else    wait_ready(tag, at);
      check_eq({tag, "_npix"},   pix_cnt, k);
      check_eq({tag, "_lat"},    first_cyc - hs_cyc, 2);
      check_eq({tag, "_end"},    at - hs_cyc, k + 2);
      check_eq({tag, "_qempty"}, exp_q.size(), 0);
   endtask

   task automatic pulse_frame_clk();
      frame_clk_rising_edge = 1'b1;
      @(negedge Clk);
      frame_clk_rising_edge = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_x"},     DrawX, 0);
      check_eq({tag, "_y"},     DrawY, 0);
      check_eq({tag, "_data"},  draw_data, 0);
      check_eq({tag, "_done"},  frame_done, 0);
      check_eq({tag, "_ready"}, line_ready, 0);
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      check_reset_outputs("rst");

      // Clear: pixel p of the scan is visible at cycle offset p+1 from release.
      Reset = 1'b0;
      rel = cyc;
      while (cyc < rel + H + 3) @(negedge Clk);
      check_eq("clr_mid_x", DrawX, 2);
      check_eq("clr_mid_y", DrawY, 1);
      check_eq("clr_mid_d", draw_data, 0);
      wait_ready("clr", t);
      check_eq("clr_cycles", t - rel + 1, HV + 1);
      check_eq("clr_last_x", DrawX, H - 1);
      check_eq("clr_last_y", DrawY, V - 1);
      check_eq("clr_last_d", draw_data, 0);

      // frame_clk outside DONE is ignored.
      pulse_frame_clk();
      check_eq("fclk_ign_ready", line_ready, 1);
      check_eq("fclk_ign_done", frame_done, 0);

      // Shallow line.
      push_pix(0, 0); push_pix(1, 0); push_pix(2, 1);
      push_pix(3, 1); push_pix(4, 2); push_pix(5, 2);
      run_line("shallow", 0, 0, 5, 2, 6, 1'b0);
      repeat (3) @(negedge Clk);
      check_eq("hold_x", DrawX, 5);
      check_eq("hold_y", DrawY, 2);
      check_eq("hold_d", draw_data, 1);

      // Steep reversed line.
      push_pix(3, 7); push_pix(3, 6); push_pix(2, 5); push_pix(2, 4);
      push_pix(2, 3); push_pix(1, 2); push_pix(1, 1);
      run_line("steep", 3, 7, 1, 1, 7, 1'b0);

      // frame_end during DRAW is remembered; DONE follows the line.
      for (int i = 20; i <= 24; i++) push_pix(i, 4);
      send_line(20, 4, 24, 4, 1'b0);
      frame_end = 1'b1;
      @(negedge Clk);
      frame_end = 1'b0;
      wait_done("pend", t);
      check_eq("pend_npix", pix_cnt, 5);
      check_eq("pend_end", t - hs_cyc, 7);
      check_eq("pend_ready", line_ready, 0);
      pulse_frame_clk();
      check_eq("fclk_done_drop", frame_done, 0);
      @(negedge Clk);
      check_eq("reclr_x", DrawX, 0);
      check_eq("reclr_y", DrawY, 0);
      check_eq("reclr_d", draw_data, 0);
      wait_ready("reclr", t);

      // Degenerate segment with frame_end in the same cycle.
      push_pix(10, 10);
      run_line("degen", 10, 10, 10, 10, 1, 1'b1);
      check_eq("degen_x", DrawX, 10);
      check_eq("degen_y", DrawY, 10);
      pulse_frame_clk();
      check_eq("degen_done_drop", frame_done, 0);
      wait_ready("reclr2", t);

      // Vertical line, then a lone frame_end in IDLE.
      for (int i = 9; i <= 12; i++) push_pix(7, i);
      run_line("vert", 7, 9, 7, 12, 4, 1'b0);
      frame_end = 1'b1;
      @(negedge Clk);
      frame_end = 1'b0;
      check_eq("idle_fe_done", frame_done, 1);
      check_eq("idle_fe_ready", line_ready, 0);
      pulse_frame_clk();
      wait_ready("reclr3", t);

`ifdef RASTER_CLIP_EN
      // Off-screen tail is stepped but not written; outputs hold at the last on-screen pixel.
      for (int i = 28; i < H; i++) push_pix(i, 0);
      send_line(28, 0, 35, 0, 1'b0);
      wait_ready("clip", t);
      check_eq("clip_npix", pix_cnt, 4);
      check_eq("clip_end", t - hs_cyc, 10);
      check_eq("clip_hold_x", DrawX, H - 1);
      check_eq("clip_hold_y", DrawY, 0);
`endif

      // Reset in the middle of a long line.
      for (int i = 0; i < H; i++) push_pix(i, 5);
      send_line(0, 5, H - 1, 5, 1'b0);
      repeat (5) @(negedge Clk);
      Reset = 1'b1;
      exp_q.delete();
      @(negedge Clk);
      check_reset_outputs("midrst");
      Reset = 1'b0;
      rel = cyc;
      wait_ready("midrst_clr", t);
      check_eq("midrst_clr_cycles", t - rel + 1, HV + 1);
      check_eq("midrst_last_d", draw_data, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
